// File: rtl/sne_evt_stream_pkg.sv
// Shared types and widths for the event-stream engine weight path.
package sne_evt_stream_pkg;

  localparam int WEIGHT_WIDTH = 8;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } evt_arb_state_t;

endpackage

// File: rtl/evt_weight_mem_arbiter_if.sv
// Loader-side request bus and bank-side write/read bus of the weight-memory arbiter.
interface evt_weight_mem_arbiter_if
  import sne_evt_stream_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DP_GROUP     = 16,
  parameter int ADDR_WIDTH   = 7,
  parameter int WEIGHT_WIDTH = sne_evt_stream_pkg::WEIGHT_WIDTH
);
  localparam int BAW = ADDR_WIDTH - 1;

  logic [NUM_REQ-1:0]                             req_i;
  logic [NUM_REQ-1:0]                             done_i;
  logic [NUM_REQ-1:0][BAW-1:0]                    req_rd_addr_i;
  logic [NUM_REQ-1:0][BAW-1:0]                    req_wr_addr_i;
  logic [NUM_REQ-1:0]                             req_rd_en_i;
  logic [NUM_REQ-1:0]                             req_wr_en_i;
  logic [NUM_REQ-1:0][DP_GROUP*WEIGHT_WIDTH-1:0]  req_weight_i;

  logic [NUM_REQ-1:0]                             grant_o;
  logic [DP_GROUP-1:0][BAW-1:0]                   group_rd_addr_o;
  logic [DP_GROUP-1:0][BAW-1:0]                   group_wr_addr_o;
  logic [DP_GROUP-1:0]                            group_rd_en_o;
  logic [DP_GROUP-1:0]                            group_wr_en_o;
  logic [DP_GROUP-1:0][WEIGHT_WIDTH-1:0]          group_weight_o;

  modport master (
    output req_i, done_i, req_rd_addr_i, req_wr_addr_i, req_rd_en_i, req_wr_en_i, req_weight_i,
    input  grant_o, group_rd_addr_o, group_wr_addr_o, group_rd_en_o, group_wr_en_o, group_weight_o
  );

  modport slave (
    input  req_i, done_i, req_rd_addr_i, req_wr_addr_i, req_rd_en_i, req_wr_en_i, req_weight_i,
    output grant_o, group_rd_addr_o, group_wr_addr_o, group_rd_en_o, group_wr_en_o, group_weight_o
  );
endinterface

// File: rtl/evt_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module evt_rr_picker #(
  parameter int NUM_REQ = 4,
  localparam int IW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [IW-1:0]      idx_o,
  output logic               valid_o
);
  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_i} + (IW+1)'(i);
      if (sum >= (IW+1)'(NUM_REQ)) begin
        sum = sum - (IW+1)'(NUM_REQ);
      end
      cand = sum[IW-1:0];
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end
endmodule

// File: rtl/evt_weight_mem_arbiter.sv
// Round-robin owner of the weight-bank port: one locked burst per grant,
// owner's bus registered onto every bank lane.
module evt_weight_mem_arbiter
  import sne_evt_stream_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DP_GROUP   = 16,
  parameter int ADDR_WIDTH = 7,
  parameter int BURST_LEN  = 64,
  parameter int TIMEOUT    = 255
) (
  input  logic                       engine_clk_i,
  input  logic                       engine_rst_ni,
  input  logic                       enable_i,
  evt_weight_mem_arbiter_if.slave    bus,
  output logic [$clog2(NUM_REQ)-1:0] owner_o,
  output logic                       busy_o,
  output logic                       timeout_o
);
  localparam int IW  = $clog2(NUM_REQ);
  localparam int BAW = ADDR_WIDTH - 1;
  localparam int BW  = $clog2(BURST_LEN) + 1;
  localparam int TW  = $clog2(TIMEOUT) + 1;
  localparam int DW  = DP_GROUP * WEIGHT_WIDTH;

  evt_arb_state_t     state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic [TW-1:0]      idle_q, idle_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;

  logic [BAW-1:0]     rd_addr_q, wr_addr_q;
  logic               rd_en_q, wr_en_q;
  logic [DW-1:0]      weight_q;

  logic [IW-1:0]      pick_idx;
  logic               pick_valid;
  logic               own_wr, own_done;

  evt_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i   (bus.req_i),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign own_wr   = bus.req_wr_en_i[owner_q];
  assign own_done = bus.done_i[owner_q];

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    beat_d    = beat_q;
    idle_d    = idle_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (enable_i && pick_valid) begin
          owner_d = pick_idx;
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
          busy_d  = 1'b1;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (own_wr) begin
          beat_d = beat_q + BW'(1);
          idle_d = '0;
        end else begin
          idle_d = idle_q + TW'(1);
        end
        // Burst end wins over timeout so a final beat is never flagged as forced.
        if (own_done || (own_wr && beat_q == BW'(BURST_LEN - 1))) begin
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = ARB_RELEASE;
        end else if (idle_q == TW'(TIMEOUT)) begin
          grant_d   = '0;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
          state_d   = ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        ptr_d   = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
        beat_d  = '0;
        idle_d  = '0;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge engine_clk_i or negedge engine_rst_ni) begin
    if (!engine_rst_ni) begin
      state_q   <= ARB_IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      beat_q    <= '0;
      idle_q    <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      beat_q    <= beat_d;
      idle_q    <= idle_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  // Bank lanes follow the owner one cycle late; outside a grant only enables drop.
  always_ff @(posedge engine_clk_i or negedge engine_rst_ni) begin
    if (!engine_rst_ni) begin
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      weight_q  <= '0;
    end else if (state_q == ARB_GRANT) begin
      rd_addr_q <= bus.req_rd_addr_i[owner_q];
      wr_addr_q <= bus.req_wr_addr_i[owner_q];
      rd_en_q   <= bus.req_rd_en_i[owner_q];
      wr_en_q   <= own_wr;
      weight_q  <= bus.req_weight_i[owner_q];
    end else begin
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
    end
  end

  assign bus.grant_o         = grant_q;
  assign bus.group_rd_addr_o = {DP_GROUP{rd_addr_q}};
  assign bus.group_wr_addr_o = {DP_GROUP{wr_addr_q}};
  assign bus.group_rd_en_o   = {DP_GROUP{rd_en_q}};
  assign bus.group_wr_en_o   = {DP_GROUP{wr_en_q}};
  assign bus.group_weight_o  = weight_q;
  assign owner_o             = owner_q;
  assign busy_o              = busy_q;
  assign timeout_o           = timeout_q;
endmodule

// File: tb/tb_evt_weight_mem_arbiter.sv
// Bench for evt_weight_mem_arbiter: burst-level reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_evt_weight_mem_arbiter;
  import sne_evt_stream_pkg::*;

  localparam int N   = 4;
  localparam int DP  = 16;
  localparam int AW  = 7;
  localparam int BL  = 64;
  localparam int TO  = 255;
  localparam int WW  = WEIGHT_WIDTH;
  localparam logic [127:0] PAT = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] owner;
  logic       busy, tmo;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;
  int wr_seen  = 0;
  int ones_seen = 0;

  always #5 clk = ~clk;

  evt_weight_mem_arbiter_if #(.NUM_REQ(N), .DP_GROUP(DP), .ADDR_WIDTH(AW), .WEIGHT_WIDTH(WW)) bus ();

  evt_weight_mem_arbiter #(.NUM_REQ(N), .DP_GROUP(DP), .ADDR_WIDTH(AW), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .engine_clk_i  (clk),
    .engine_rst_ni (rst_n),
    .enable_i      (enable),
    .bus           (bus),
    .owner_o       (owner),
    .busy_o        (busy),
    .timeout_o     (tmo)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (burst-level rules) ----------------
  logic         m_active;
  logic [1:0]   m_owner, m_ptr;
  int           m_beats, m_idle, m_cool;
  logic [3:0]   e_grant;
  logic         e_busy, e_timeout, e_rd_en, e_wr_en;
  logic [1:0]   e_owner;
  logic [5:0]   e_rd_addr, e_wr_addr;
  logic [127:0] e_weight;

  function automatic logic [1:0] pick_owner(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] c;
    for (int k = 0; k < 4; k++) begin
      c = ptr + 2'(k);
      if (req[c]) return c;
    end
    return 2'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_owner <= '0; m_ptr <= '0;
      m_beats <= 0; m_idle <= 0; m_cool <= 0;
      e_grant <= '0; e_busy <= 1'b0; e_timeout <= 1'b0; e_owner <= '0;
      e_rd_en <= 1'b0; e_wr_en <= 1'b0; e_rd_addr <= '0; e_wr_addr <= '0; e_weight <= '0;
    end else if (m_active) begin
      e_rd_en   <= bus.req_rd_en_i[m_owner];
      e_wr_en   <= bus.req_wr_en_i[m_owner];
      e_rd_addr <= bus.req_rd_addr_i[m_owner];
      e_wr_addr <= bus.req_wr_addr_i[m_owner];
      e_weight  <= bus.req_weight_i[m_owner];
      if (bus.done_i[m_owner] || (bus.req_wr_en_i[m_owner] && m_beats == BL - 1) || m_idle == TO) begin
        m_active  <= 1'b0;
        e_grant   <= '0;
        e_busy    <= 1'b0;
        e_timeout <= !bus.done_i[m_owner] && !(bus.req_wr_en_i[m_owner] && m_beats == BL - 1);
        m_ptr     <= m_owner + 2'd1;
        m_cool    <= 1;
        m_beats   <= 0;
        m_idle    <= 0;
      end else begin
        m_beats <= m_beats + (bus.req_wr_en_i[m_owner] ? 1 : 0);
        m_idle  <= bus.req_wr_en_i[m_owner] ? 0 : m_idle + 1;
      end
    end else begin
      e_rd_en   <= 1'b0;
      e_wr_en   <= 1'b0;
      e_timeout <= 1'b0;
      if (m_cool > 0) begin
        m_cool <= m_cool - 1;
      end else if (enable && bus.req_i != 4'b0) begin
        m_active <= 1'b1;
        m_owner  <= pick_owner(bus.req_i, m_ptr);
        e_owner  <= pick_owner(bus.req_i, m_ptr);
        e_grant  <= 4'b0001 << pick_owner(bus.req_i, m_ptr);
        e_busy   <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("grant", 128'(bus.grant_o), 128'(e_grant));
      check("busy", 128'(busy), 128'(e_busy));
      check("owner", 128'(owner), 128'(e_owner));
      check("timeout", 128'(tmo), 128'(e_timeout));
      check("bank_rd_en", 128'(bus.group_rd_en_o), 128'({DP{e_rd_en}}));
      check("bank_wr_en", 128'(bus.group_wr_en_o), 128'({DP{e_wr_en}}));
      check("bank_rd_addr", 128'(bus.group_rd_addr_o), 128'({DP{e_rd_addr}}));
      check("bank_wr_addr", 128'(bus.group_wr_addr_o), 128'({DP{e_wr_addr}}));
      check("bank_weight", 128'(bus.group_weight_o), e_weight);
    end
  end

  // Event monitor; the bench reads differences of these counters.
  always @(negedge clk) begin
    if (bus.group_wr_en_o[0]) wr_seen <= wr_seen + 1;
    if (128'(bus.group_weight_o) == {128{1'b1}}) ones_seen <= ones_seen + 1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_i = '0; bus.done_i = '0; bus.req_rd_en_i = '0; bus.req_wr_en_i = '0;
    bus.req_rd_addr_i = '0; bus.req_wr_addr_i = '0; bus.req_weight_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_beat(input logic [1:0] r, input int i, input logic wr);
    bus.req_wr_en_i[r]   = wr;
    bus.req_rd_en_i[r]   = wr & i[0];
    bus.req_wr_addr_i[r] = 6'(i);
    bus.req_rd_addr_i[r] = 6'(63 - i);
    bus.req_weight_i[r]  = PAT ^ {16{8'(i)}} ^ {32{2'b00, r}};
  endtask

  task automatic wait_grant(output int gap);
    gap = 0;
    for (int t = 0; t < 300; t++) begin
      if (bus.grant_o != 4'b0) return;
      gap++;
      tick();
    end
    check("grant_wait_bound", 128'(bus.grant_o != 4'b0), 128'(1));
  endtask

  task automatic release_owner(input logic [1:0] r);
    set_beat(r, 0, 1'b0);
    bus.done_i[r] = 1'b1;
    bus.req_i[r]  = 1'b0;
    tick();
    bus.done_i[r] = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int gap, base, base1, gcnt, tp;
    logic [1:0] cur;
    logic [1:0] order [5];
    logic [1:0] exp_order [5];
    exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    check("rst_grant", 128'(bus.grant_o), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_wr_en", 128'(bus.group_wr_en_o), 128'(0));
    enable = 1'b1;

    // Single loader: 64-beat burst ends on its own, pointer moves to 2.
    bus.req_i = 4'b0010;
    tick();
    check("t1_grant_1cyc", 128'(bus.grant_o), 128'(4'b0010));
    base = wr_seen;
    for (int i = 0; i < BL; i++) begin
      set_beat(2'd1, i, 1'b1);
      if (i == BL - 1) bus.req_i = 4'b0;
      tick();
    end
    set_beat(2'd1, 0, 1'b0);
    check("t1_release_after_64", 128'(bus.grant_o), 128'(0));
    tick();
    check("t1_bank_writes", 128'(wr_seen - base), 128'(64));
    bus.req_i = 4'b0101;
    wait_grant(gap);
    check("t1_next_owner_ptr2", 128'(owner), 128'(2));
    bus.req_i = 4'b0000;
    release_owner(2'd2);
    tick();

    // All requesting: round-robin order with exactly two idle cycles between bursts.
    do_reset();
    bus.req_i = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      wait_grant(gap);
      if (b > 0) check("t2_gap", 128'(gap), 128'(2));
      order[b] = owner;
      cur = owner;
      for (int i = 0; i < 3; i++) begin
        set_beat(cur, i + 8 * b, 1'b1);
        tick();
      end
      if (b == 4) bus.req_i = 4'b0;
      release_owner(cur);
      if (b < 4) bus.req_i[cur] = 1'b1;
    end
    for (int b = 0; b < 5; b++) check("t2_order", 128'(order[b]), 128'(exp_order[b]));
    tick();

    // Timeout: owner 1 silent, forced release after 256 grant cycles, owner 3 next.
    do_reset();
    bus.req_i = 4'b1010;
    wait_grant(gap);
    check("t3_first_owner", 128'(owner), 128'(1));
    gcnt = 0;
    tp = 0;
    for (int t = 0; t < 600; t++) begin
      if (bus.grant_o == 4'b0010) gcnt++;
      if (tmo) tp++;
      if (bus.grant_o == 4'b1000) break;
      tick();
    end
    check("t3_grant_cycles", 128'(gcnt), 128'(256));
    check("t3_timeout_pulses", 128'(tp), 128'(1));
    check("t3_next_owner", 128'(owner), 128'(3));
    bus.req_i = 4'b0;
    release_owner(2'd3);
    tick();

    // Isolation: loader 3 drives all-ones writes and done while loader 0 owns.
    do_reset();
    bus.req_i = 4'b0001;
    bus.req_wr_en_i[3] = 1'b1;
    bus.req_rd_en_i[3] = 1'b1;
    bus.req_wr_addr_i[3] = 6'h3F;
    bus.req_rd_addr_i[3] = 6'h3F;
    bus.req_weight_i[3] = '1;
    bus.done_i[3] = 1'b1;
    base  = wr_seen;
    base1 = ones_seen;
    wait_grant(gap);
    check("t4_owner", 128'(owner), 128'(0));
    for (int i = 0; i < 3; i++) begin
      set_beat(2'd0, i + 20, 1'b1);
      tick();
    end
    release_owner(2'd0);
    repeat (3) tick();
    check("t4_owner_writes_only", 128'(wr_seen - base), 128'(3));
    check("t4_no_all_ones", 128'(ones_seen - base1), 128'(0));
    clear_inputs();
    tick();

    // Enable drop mid-burst: burst completes, then no grant until re-enabled.
    do_reset();
    bus.req_i = 4'b0100;
    wait_grant(gap);
    check("t5_owner", 128'(owner), 128'(2));
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        enable = 1'b0;
        bus.req_i = 4'b1111;
      end
      set_beat(2'd2, i + 40, 1'b1);
      tick();
    end
    check("t5_grant_held", 128'(bus.grant_o), 128'(4'b0100));
    release_owner(2'd2);
    gcnt = 0;
    for (int t = 0; t < 20; t++) begin
      if (bus.grant_o != 4'b0) gcnt++;
      tick();
    end
    check("t5_no_grant_disabled", 128'(gcnt), 128'(0));
    enable = 1'b1;
    wait_grant(gap);
    check("t5_owner_after_enable", 128'(owner), 128'(3));

    // Asynchronous reset mid-burst, then arbitration restarts at index 0.
    set_beat(2'd3, 5, 1'b1);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_grant", 128'(bus.grant_o), 128'(0));
    check("t6_rst_busy", 128'(busy), 128'(0));
    check("t6_rst_wr_en", 128'(bus.group_wr_en_o), 128'(0));
    check("t6_rst_weight", 128'(bus.group_weight_o), 128'(0));
    check("t6_rst_owner", 128'(owner), 128'(0));
    clear_inputs();
    bus.req_i = 4'b1111;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_grant(gap);
    check("t6_restart_owner", 128'(owner), 128'(0));
    bus.req_i = 4'b0;
    release_owner(2'd0);
    repeat (3) tick();

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
